// File: rtl/fft_sched_pkg.sv
// Shared types and width helpers for the FFT stage scheduler.
package fft_sched_pkg;

  // Scheduler FSM states.
  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_GAP,
    S_DRAIN,
    S_DONE
  } sched_state_t;

  // Width of the stage index for an FFT of 2**n_log2 points.
  function automatic int stage_width(input int n_log2);
    return (n_log2 < 2) ? 1 : $clog2(n_log2);
  endfunction

  // Width of the butterfly counter k (0 .. N/2-1) and of the twiddle index.
  function automatic int k_width(input int n_log2);
    return n_log2 - 1;
  endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational radix-2 DIT address generator: (stage s, butterfly k) -> a, b, tw.
module fft_addr_gen
  import fft_sched_pkg::*;
#(
  parameter int N_LOG2 = 5
) (
  input  logic [stage_width(N_LOG2)-1:0] s,
  input  logic [k_width(N_LOG2)-1:0]     k,
  output logic [N_LOG2-1:0]              a,
  output logic [N_LOG2-1:0]              b,
  output logic [k_width(N_LOG2)-1:0]     tw
);

  localparam int KW = k_width(N_LOG2);
  localparam logic [N_LOG2-1:0] ONE_N = N_LOG2'(1);
  localparam logic [KW-1:0]     ONE_K = KW'(1);

  logic [N_LOG2-1:0] k_ext;
  logic [N_LOG2-1:0] span;
  logic [KW-1:0]     pos;

  // Split k into group and position, then place the pair 'span' apart.
  always_comb begin
    // NOTE: every variable assigned here gets a value on every path, so no latch is inferred.
    k_ext = {1'b0, k};
    span  = ONE_N << s;
    // At the last stage ONE_K << s wraps to zero, so the mask becomes all ones -- exactly what is wanted.
    pos   = k & ((ONE_K << s) - ONE_K);
    a     = (((k_ext >> s) << s) << 1) | {1'b0, pos};
    // Bit s of a is always clear, so OR is the same as adding span.
    b     = a | span;
    tw    = pos << (KW - int'(s));
  end

endmodule

// File: rtl/fft_stage_scheduler.sv
// In-place radix-2 DIT FFT stage scheduler: sequences butterflies over all
// stages, issues operand reads and delayed write-backs, honours stall.
module fft_stage_scheduler
  import fft_sched_pkg::*;
#(
  parameter int N_LOG2    = 5,
  parameter int PRECISION = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            stall,
  output logic                            rd_en,
  output logic [N_LOG2-1:0]               rd_addr_a,
  output logic [N_LOG2-1:0]               rd_addr_b,
  output logic [k_width(N_LOG2)-1:0]      tw_addr,
  output logic                            wr_en,
  output logic [N_LOG2-1:0]               wr_addr_a,
  output logic [N_LOG2-1:0]               wr_addr_b,
  output logic [stage_width(N_LOG2)-1:0]  stage,
  output logic                            busy,
  output logic                            done,
  output logic                            prec_sel
);

  localparam int SW = stage_width(N_LOG2);
  localparam int KW = k_width(N_LOG2);
  localparam logic [SW-1:0] LAST_STAGE = SW'(N_LOG2 - 1);
  localparam logic [KW-1:0] K_LAST     = '1;

  sched_state_t      state;
  logic [SW-1:0]     stage_q;
  logic [KW-1:0]     k_q;
  logic              busy_q;
  logic              done_q;
  logic              rd_fire;
  logic [N_LOG2-1:0] gen_a;
  logic [N_LOG2-1:0] gen_b;
  logic [KW-1:0]     gen_tw;
  logic              wr_en_q;
  logic [N_LOG2-1:0] wr_a_q;
  logic [N_LOG2-1:0] wr_b_q;

  fft_addr_gen #(.N_LOG2(N_LOG2)) u_addr_gen (
    .s  (stage_q),
    .k  (k_q),
    .a  (gen_a),
    .b  (gen_b),
    .tw (gen_tw)
  );

  // Stage sequencing FSM; everything except a start in IDLE freezes on stall.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (rst) begin
      state   <= S_IDLE;
      stage_q <= '0;
      k_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_RUN;
            busy_q  <= 1'b1;
            stage_q <= '0;
            k_q     <= '0;
          end
        end
        S_RUN: begin
          if (!stall) begin
            if (k_q == K_LAST) begin
              k_q   <= '0;
              state <= (stage_q == LAST_STAGE) ? S_DRAIN : S_GAP;
            end else begin
              k_q <= k_q + KW'(1);
            end
          end
        end
        S_GAP: begin
          if (!stall) begin
            state   <= S_RUN;
            stage_q <= stage_q + SW'(1);
          end
        end
        S_DRAIN: begin
          if (!stall) begin
            state  <= S_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (!stall) begin
            state   <= S_IDLE;
            done_q  <= 1'b0;
            stage_q <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // One-cycle read latency: the pair read now is written back next non-stalled cycle.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the write pipeline is reset so no pending write-back survives a reset.
    if (rst) begin
      wr_en_q <= 1'b0;
      wr_a_q  <= '0;
      wr_b_q  <= '0;
    end else if (!stall) begin
      wr_en_q <= rd_fire;
      wr_a_q  <= rd_addr_a;
      wr_b_q  <= rd_addr_b;
    end
  end

  assign rd_fire   = (state == S_RUN) && !stall;
  assign rd_en     = rd_fire;
  assign rd_addr_a = rd_fire ? gen_a  : '0;
  assign rd_addr_b = rd_fire ? gen_b  : '0;
  assign tw_addr   = rd_fire ? gen_tw : '0;

  assign wr_en     = wr_en_q && !stall;
  assign wr_addr_a = wr_en ? wr_a_q : '0;
  assign wr_addr_b = wr_en ? wr_b_q : '0;

  assign stage     = stage_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign prec_sel  = (PRECISION != 0) ? 1'b1 : 1'b0;

endmodule

// File: tb/tb_fft_stage_scheduler.sv
// Self-checking bench for fft_stage_scheduler (N_LOG2=3) with an address scoreboard.
module tb_fft_stage_scheduler;

  localparam int N_LOG2    = 3;
  localparam int PRECISION = 0;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stall;
  logic       rd_en;
  logic [2:0] rd_addr_a;
  logic [2:0] rd_addr_b;
  logic [1:0] tw_addr;
  logic       wr_en;
  logic [2:0] wr_addr_a;
  logic [2:0] wr_addr_b;
  logic [1:0] stage;
  logic       busy;
  logic       done;
  logic       prec_sel;

  fft_stage_scheduler #(.N_LOG2(N_LOG2), .PRECISION(PRECISION)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stall     (stall),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .tw_addr   (tw_addr),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b),
    .stage     (stage),
    .busy      (busy),
    .done      (done),
    .prec_sel  (prec_sel)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic [1:0] tw;
    logic [1:0] st;
  } rd_exp_t;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
  } wr_exp_t;

  rd_exp_t exp_rd[$];
  wr_exp_t exp_wr[$];

  int total  = 0;
  int bad    = 0;
  int n_rd   = 0;
  int n_wr   = 0;
  int n_done = 0;

  // Reference read sequence built group-by-group, independent of the k bit-slicing form.
  task automatic push_fft();
    rd_exp_t e;
    for (int s = 0; s < N_LOG2; s++) begin
      int span;
      span = 1 << s;
      for (int g = 0; g < 4 / span; g++) begin
        for (int j = 0; j < span; j++) begin
          e.a  = 3'(g * 2 * span + j);
          e.b  = 3'(g * 2 * span + j + span);
          e.tw = 2'(j * (4 / span));
          e.st = 2'(s);
          exp_rd.push_back(e);
        end
      end
    end
  endtask

  // Scoreboard: called once per cycle at the falling edge.
  task automatic sb_sample();
    rd_exp_t er;
    wr_exp_t ew;
    if (wr_en === 1'b1) begin
      n_wr++;
      total++;
      if (exp_wr.size() == 0) begin
        bad++;
        $display("FAIL sb_wr_unexpected: got a=%0d b=%0d, wanted no write", wr_addr_a, wr_addr_b);
      end else begin
        ew = exp_wr.pop_front();
        if ({wr_addr_a, wr_addr_b} !== ew) begin
          bad++;
          $display("FAIL sb_wr_addr: got a=%0d b=%0d, wanted a=%0d b=%0d",
                   wr_addr_a, wr_addr_b, ew.a, ew.b);
        end
      end
    end
    if (rd_en === 1'b1) begin
      n_rd++;
      total++;
      if (exp_rd.size() == 0) begin
        bad++;
        $display("FAIL sb_rd_unexpected: got a=%0d b=%0d, wanted no read", rd_addr_a, rd_addr_b);
      end else begin
        er = exp_rd.pop_front();
        if ({rd_addr_a, rd_addr_b, tw_addr, stage} !== er) begin
          bad++;
          $display("FAIL sb_rd_addr: got a=%0d b=%0d tw=%0d st=%0d, wanted a=%0d b=%0d tw=%0d st=%0d",
                   rd_addr_a, rd_addr_b, tw_addr, stage, er.a, er.b, er.tw, er.st);
        end
        exp_wr.push_back({er.a, er.b});
      end
    end
    if (done === 1'b1) n_done++;
  endtask

  // Nominal timing with start at edge 0: {rd_en, wr_en, busy, done} in cycle c.
  function automatic bit base_rd(input int c);
    return (c >= 1 && c <= 4) || (c >= 6 && c <= 9) || (c >= 11 && c <= 14);
  endfunction

  function automatic logic [3:0] exp_vec(input int c);
    return {base_rd(c), base_rd(c - 1), (c >= 1 && c <= 15), (c == 16)};
  endfunction

  // Drives start into edge 0; returns just after that edge.
  task automatic launch(input bit with_stall);
    n_rd   = 0;
    n_wr   = 0;
    n_done = 0;
    push_fft();
    start = 1'b1;
    stall = with_stall;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic check_drained(input string name);
    total++;
    if (n_wr !== 12 || n_done !== 1 || exp_rd.size() !== 0 || exp_wr.size() !== 0) begin
      bad++;
      $display("FAIL %s_totals: got writes=%0d done=%0d left_rd=%0d left_wr=%0d, wanted 12 1 0 0",
               name, n_wr, n_done, exp_rd.size(), exp_wr.size());
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    #2;
    total++;
    if ({rd_en, wr_en, busy, done, stage, rd_addr_a, wr_addr_a, tw_addr} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got rd=%b wr=%b busy=%b done=%b stage=%0d, wanted all 0",
               rd_en, wr_en, busy, done, stage);
    end
    total++;
    if (prec_sel !== 1'b0) begin
      bad++;
      $display("FAIL reset_prec_sel: got %b, wanted 0", prec_sel);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [3:0] obs;
    launch(1'b0);
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      sb_sample();
      obs = {rd_en, wr_en, busy, done};
      total++;
      if (obs !== exp_vec(c)) begin
        bad++;
        $display("FAIL basic_timing c=%0d: got rd/wr/busy/done=%b, wanted %b", c, obs, exp_vec(c));
      end
      if (c == 4 || c == 7 || c == 14) begin
        logic [7:0] want;
        want = (c == 4) ? {3'd6, 3'd7, 2'd0} : (c == 7) ? {3'd1, 3'd3, 2'd2} : {3'd3, 3'd7, 2'd3};
        total++;
        if ({rd_addr_a, rd_addr_b, tw_addr} !== want) begin
          bad++;
          $display("FAIL basic_addr c=%0d: got a=%0d b=%0d tw=%0d, wanted %h",
                   c, rd_addr_a, rd_addr_b, tw_addr, want);
        end
      end
      @(posedge clk);
      #1;
    end
    check_drained("basic");
  endtask

  task automatic test_stall();
    logic [3:0] obs;
    logic [3:0] want;
    int done_cyc;
    done_cyc = -1;
    launch(1'b0);
    for (int c = 1; c <= 20; c++) begin
      if (c == 7)  stall = 1'b1;
      if (c == 10) stall = 1'b0;
      @(negedge clk);
      sb_sample();
      if (done === 1'b1) done_cyc = c;
      obs  = {rd_en, wr_en, busy, done};
      want = (c < 7) ? exp_vec(c) : (c <= 9) ? 4'b0010 : exp_vec(c - 3);
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL stall_timing c=%0d: got rd/wr/busy/done=%b, wanted %b", c, obs, want);
      end
      @(posedge clk);
      #1;
    end
    total++;
    if (done_cyc !== 19) begin
      bad++;
      $display("FAIL stall_done_cycle: got %0d, wanted 19", done_cyc);
    end
    check_drained("stall");
  endtask

  task automatic test_reset_mid();
    launch(1'b0);
    for (int c = 1; c <= 8; c++) begin
      if (c == 8) rst = 1'b1;
      @(negedge clk);
      sb_sample();
      if (c == 8) begin
        total++;
        if ({rd_en, wr_en, busy, done, stage, rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b} !== '0) begin
          bad++;
          $display("FAIL midreset_outputs: got rd=%b wr=%b busy=%b done=%b stage=%0d, wanted all 0",
                   rd_en, wr_en, busy, done, stage);
        end
      end
      @(posedge clk);
      #1;
    end
    exp_rd.delete();
    exp_wr.delete();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if ({rd_en, wr_en, busy, done} !== 4'b0000) begin
        bad++;
        $display("FAIL midreset_idle c=%0d: got rd/wr/busy/done=%b, wanted 0000",
                 c, {rd_en, wr_en, busy, done});
      end
      @(posedge clk);
      #1;
    end
    launch(1'b0);
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      if (c == 1) begin
        total++;
        if ({rd_en, rd_addr_a, rd_addr_b} !== {1'b1, 3'd0, 3'd1}) begin
          bad++;
          $display("FAIL midreset_first_read: got en=%b a=%0d b=%0d, wanted 1 0 1",
                   rd_en, rd_addr_a, rd_addr_b);
        end
      end
      sb_sample();
      total++;
      if ({rd_en, wr_en, busy, done} !== exp_vec(c)) begin
        bad++;
        $display("FAIL midreset_rerun c=%0d: got %b, wanted %b", c, {rd_en, wr_en, busy, done}, exp_vec(c));
      end
      @(posedge clk);
      #1;
    end
    check_drained("midreset");
  endtask

  task automatic test_restart_ignored();
    launch(1'b0);
    for (int c = 1; c <= 17; c++) begin
      start = (c == 5);
      @(negedge clk);
      sb_sample();
      total++;
      if ({rd_en, wr_en, busy, done} !== exp_vec(c)) begin
        bad++;
        $display("FAIL restart_timing c=%0d: got %b, wanted %b", c, {rd_en, wr_en, busy, done}, exp_vec(c));
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    check_drained("restart");
  endtask

  task automatic test_start_with_stall();
    logic [3:0] want;
    launch(1'b1);
    for (int c = 1; c <= 19; c++) begin
      stall = (c <= 2);
      @(negedge clk);
      sb_sample();
      want = (c <= 2) ? 4'b0010 : exp_vec(c - 2);
      total++;
      if ({rd_en, wr_en, busy, done} !== want) begin
        bad++;
        $display("FAIL startstall_timing c=%0d: got %b, wanted %b", c, {rd_en, wr_en, busy, done}, want);
      end
      @(posedge clk);
      #1;
    end
    stall = 1'b0;
    check_drained("startstall");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_reset_mid();
    test_restart_ignored();
    test_start_with_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_stage_scheduler.md
FFT_STAGE_SCHEDULER -- requirements
Module: fft_stage_scheduler

Interface
REQ-001 SHALL have parameter N_LOG2, default 5; log2 of the FFT length N (supported range 2..10).
REQ-002 SHALL have parameter PRECISION, default 0; 0 = FP4, 1 = FP8; forwarded unchanged on output prec_sel for butterfly_wrapper configuration.
REQ-003 SHALL use one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-004 SHALL have rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have start  input  1  begin a full in-place radix-2 DIT FFT; sampled only in IDLE.
REQ-006 SHALL have stall  input  1  memory/datapath not ready; freezes the block.
REQ-007 SHALL have rd_en  output  1  read of the operand pair this cycle.
REQ-008 SHALL have rd_addr_a, rd_addr_b  output  N_LOG2  operand A/B addresses.
REQ-009 SHALL have tw_addr  output  N_LOG2-1  twiddle ROM index.
REQ-010 SHALL have wr_en  output  1  write-back of butterfly X/Y this cycle.
REQ-011 SHALL have wr_addr_a, wr_addr_b  output  N_LOG2  write-back addresses for X and Y.
REQ-012 SHALL have stage  output  clog2(N_LOG2)  current stage index; busy  output  1; done  output  1  one-cycle pulse; prec_sel  output  1.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, GAP, DRAIN, DONE.
REQ-014 IDLE -> RUN on start; RUN -> GAP after the last butterfly of a non-final stage; GAP -> RUN after one cycle with stage+1; RUN -> DRAIN after the last butterfly of the final stage; DRAIN -> DONE; DONE -> IDLE after one cycle.
REQ-015 In RUN, SHALL issue one butterfly per non-stalled cycle, k = 0..N/2-1 per stage: span = 1<<s, pos = k & (span-1), a = ((k>>s)<<(s+1)) | pos, b = a + span, tw = pos << (N_LOG2-1-s).
REQ-016 wr_en and wr_addr_a/b SHALL equal rd_en and rd_addr_a/b delayed by exactly one non-stalled cycle (1-cycle read latency, combinational butterfly).
REQ-017 GAP SHALL issue no read, so the last write of stage s lands before the first read of stage s+1 (RAW hazard free).
REQ-018 While stall=1, all state, counters and the write pipeline register SHALL hold; rd_en and wr_en SHALL be 0; operation resumes unchanged when stall falls.
REQ-019 start while not in IDLE SHALL be ignored; start and stall together in IDLE SHALL still launch RUN, with the first read deferred until stall falls.
REQ-020 busy SHALL be 1 in RUN, GAP and DRAIN; done SHALL be 1 only in DONE.
REQ-021 Counters SHALL wrap k to 0 on stage advance; stage SHALL never exceed N_LOG2-1.

Reset
REQ-022 rst SHALL immediately force IDLE, stage=0, k=0, and all outputs 0 (prec_sel excepted, always = PRECISION), including mid-FFT; no write completes after reset assertion.

Structure
REQ-023 fft_sched_pkg SHALL hold the FSM state enum and the address-computation width constants.
REQ-024 Address generation (REQ-015) SHALL be a combinational sub-module fft_addr_gen(s, k) -> a, b, tw.

Verification (N_LOG2=3, no stall unless stated; start sampled at edge 0)
REQ-025 Basic run: rd_en cycles 1-4, 6-9, 11-14; wr_en cycles 2-5, 7-10, 12-15; done pulse at cycle 16; busy cycles 1-15.
REQ-026 Addresses: stage0 k=3 -> a=6, b=7, tw=0; stage1 k=1 -> a=1, b=3, tw=2; stage2 k=3 -> a=3, b=7, tw=3.
REQ-027 Stall 3 cycles at cycle 7 -> no rd_en/wr_en during the stall, same address sequence afterwards, done at cycle 19.
REQ-028 rst pulse at cycle 8 -> all outputs 0 the same cycle, IDLE; a new start runs the full sequence from a=0, b=1.
REQ-029 start re-asserted at cycle 5 -> ignored; exactly 12 writes and one done pulse.
